mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline. Sits between the EX/MEM latch and the MEM/WB latch.

---
 rtl/mem_access_stage.sv | 128 ++++++++++++
 tb/tb_mem_access_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: issues one dcache request per live load/store, stalls until dhit,
// bypasses load data into the writeback mux, and latches halt and timeout flags.
module mem_access_stage #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_i,
  input  logic              dREN_i,
  input  logic              dWEN_i,
  input  logic [WORD_W-1:0] aluout_i,
  input  logic [WORD_W-1:0] rdat2_i,
  input  logic [WORD_W-1:0] pc4_i,
  input  logic [WORD_W-1:0] lui_imm_i,
  input  logic [1:0]        MemToReg_i,
  input  logic              halt_i,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] wdat_o,
  output logic              halt_o,
  output logic              err_o
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [WORD_W-1:0] load_q, load_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              mem_op;
  logic              addr_lsb_unused;

  // Word-aligned requests: the byte offset bits never reach the dcache.
  assign addr_lsb_unused = &aluout_i[1:0];

  always_comb begin
    mem_op    = valid_i & (dREN_i | dWEN_i) & (state_q != HALTED);
    dmemREN   = mem_op & dREN_i;
    dmemWEN   = mem_op & dWEN_i & ~dREN_i;
    dmemaddr  = {aluout_i[WORD_W-1:2], 2'b00};
    dmemstore = rdat2_i;
    mem_stall = mem_op & ~dhit;
  end

  // Load data is bypassed in the hit cycle so MEM/WB captures it on the same edge.
  always_comb begin
    wdat_o = aluout_i;
    case (MemToReg_i)
      2'd0:    wdat_o = aluout_i;
      2'd1:    wdat_o = dhit ? dmemload : load_q;
      2'd2:    wdat_o = pc4_i;
      default: wdat_o = lui_imm_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    load_d     = load_q;
    halt_d     = halt_q;
    err_d      = err_q;
    if (dhit & dmemREN) begin
      load_d = dmemload;
    end
    case (state_q)
      IDLE: begin
        if (mem_op & ~dhit) begin
          state_d    = WAIT;
          wait_cnt_d = 8'd1;
        end else if (valid_i & halt_i & ~mem_op) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end
      end
      WAIT: begin
        // A slow access is flagged but never abandoned; only dhit releases it.
        if (wait_cnt_q == TIMEOUT_CNT) begin
          err_d = 1'b1;
        end
        if (dhit) begin
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      HALTED: begin
        halt_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      load_q     <= '0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      load_q     <= load_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  assign halt_o = halt_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a cycle-level
// reference model of the access/halt/timeout rules.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        valid_i, dREN_i, dWEN_i, halt_i, dhit;
  logic [31:0] aluout_i, rdat2_i, pc4_i, lui_imm_i, dmemload;
  logic [1:0]  MemToReg_i;
  logic        dmemREN, dmemWEN, mem_stall, halt_o, err_o;
  logic [31:0] dmemaddr, dmemstore, wdat_o;

  int checks = 0;
  int failures = 0;

  // Reference model: is the CPU halted, is an access outstanding and for how
  // many cycles has it been outstanding, sticky error, last loaded word.
  bit          m_halted, m_pending, m_err;
  int          m_age;
  logic [31:0] m_load;

  int n_ren, n_wen, n_stall;
  logic [31:0] last_wdat;

  always #5 CLK = ~CLK;

  mem_access_stage #(.WORD_W(32), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
    .aluout_i(aluout_i), .rdat2_i(rdat2_i), .pc4_i(pc4_i), .lui_imm_i(lui_imm_i),
    .MemToReg_i(MemToReg_i), .halt_i(halt_i), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wdat_o(wdat_o), .halt_o(halt_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    RST = 1'b0; valid_i = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0; halt_i = 1'b0;
    dhit = 1'b0; aluout_i = '0; rdat2_i = '0; pc4_i = '0; lui_imm_i = '0;
    dmemload = '0; MemToReg_i = 2'd0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic tick();
    bit          op, e_stall;
    logic [31:0] e_wdat;
    @(negedge CLK);
    op      = valid_i && (dREN_i || dWEN_i) && !m_halted;
    e_stall = op && !dhit;
    case (MemToReg_i)
      2'd0:    e_wdat = aluout_i;
      2'd1:    e_wdat = dhit ? dmemload : m_load;
      2'd2:    e_wdat = pc4_i;
      default: e_wdat = lui_imm_i;
    endcase
    chk("dmemREN", 32'(dmemREN), 32'(op && dREN_i));
    chk("dmemWEN", 32'(dmemWEN), 32'(op && dWEN_i && !dREN_i));
    chk("dmemaddr", dmemaddr, aluout_i & 32'hFFFF_FFFC);
    chk("dmemstore", dmemstore, rdat2_i);
    chk("mem_stall", 32'(mem_stall), 32'(e_stall));
    chk("halt_o", 32'(halt_o), 32'(m_halted));
    chk("err_o", 32'(err_o), 32'(m_err));
    if (!e_stall) chk("wdat_o", wdat_o, e_wdat);
    n_ren += int'(dmemREN);
    n_wen += int'(dmemWEN);
    n_stall += int'(mem_stall);
    last_wdat = wdat_o;
    @(posedge CLK);
    if (RST) begin
      m_halted = 0; m_pending = 0; m_err = 0; m_age = 0; m_load = '0;
    end else begin
      if (op && dREN_i && dhit) m_load = dmemload;
      if (m_pending) begin
        // After TIMEOUT cycles spent waiting beyond the first, the access is late.
        if (m_age == TMO) m_err = 1;
        if (dhit) m_pending = 0;
        else m_age++;
      end else if (!m_halted) begin
        if (e_stall) begin
          m_pending = 1; m_age = 1;
        end else if (valid_i && halt_i && !op) begin
          m_halted = 1;
        end
      end
    end
    #1;
  endtask

  task automatic clr_counts();
    n_ren = 0; n_wen = 0; n_stall = 0;
  endtask

  task automatic do_reset();
    set_idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    m_halted = 0; m_pending = 0; m_err = 0; m_age = 0; m_load = '0;
    clr_counts();
    last_wdat = '0;
    #1;
    do_reset();
    tick();
    chk("reset_halt", 32'(halt_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_stall", 32'(mem_stall), 32'd0);

    // LW 0x104 hitting on the fourth cycle.
    clr_counts();
    valid_i = 1; dREN_i = 1; aluout_i = 32'h104; MemToReg_i = 2'd1;
    repeat (3) tick();
    dhit = 1; dmemload = 32'hDEAD_BEEF;
    tick();
    chk("lw_ren_cycles", n_ren, 4);
    chk("lw_stall_cycles", n_stall, 3);
    chk("lw_wdat", last_wdat, 32'hDEAD_BEEF);
    set_idle();
    tick();

    // SW 0x0FF with a zero-wait hit.
    clr_counts();
    valid_i = 1; dWEN_i = 1; aluout_i = 32'h0FF; rdat2_i = 32'h1234_5678; dhit = 1;
    tick();
    chk("sw_addr", dmemaddr, 32'h0FC);
    chk("sw_wen_cycles", n_wen, 1);
    chk("sw_stall_cycles", n_stall, 0);
    set_idle();
    tick();

    // Timeout: dhit withheld for 10 cycles, then completes; err stays until reset.
    valid_i = 1; dREN_i = 1; aluout_i = 32'h200; MemToReg_i = 2'd1;
    repeat (10) tick();
    chk("tmo_err_set", 32'(err_o), 32'd1);
    dhit = 1; dmemload = 32'hCAFE_0001;
    tick();
    set_idle();
    repeat (2) tick();
    chk("tmo_err_sticky", 32'(err_o), 32'd1);
    do_reset();
    tick();
    chk("tmo_err_cleared", 32'(err_o), 32'd0);

    // HALT, then a load must be ignored.
    valid_i = 1; halt_i = 1;
    tick();
    halt_i = 0;
    clr_counts();
    dREN_i = 1; aluout_i = 32'h300;
    repeat (3) tick();
    chk("halt_sticky", 32'(halt_o), 32'd1);
    chk("halt_no_req", n_ren + n_stall, 0);

    // Reset while an access is waiting.
    do_reset();
    valid_i = 1; dREN_i = 1; aluout_i = 32'h400;
    repeat (2) tick();
    RST = 1;
    tick();
    set_idle();
    clr_counts();
    tick();
    chk("rst_wait_req", n_ren + n_wen + n_stall, 0);
    chk("rst_wait_halt", 32'(halt_o), 32'd0);

    // MemToReg sweep with a hit.
    begin
      logic [31:0] sweep_exp [4];
      sweep_exp[0] = 32'd1; sweep_exp[1] = 32'd4; sweep_exp[2] = 32'd2; sweep_exp[3] = 32'd3;
      for (int i = 0; i < 4; i++) begin
        valid_i = 1; dREN_i = 1; dhit = 1; dmemload = 32'd4;
        aluout_i = 32'd1; pc4_i = 32'd2; lui_imm_i = 32'd3; MemToReg_i = 2'(i);
        tick();
        chk("mtr_sweep", last_wdat, sweep_exp[i]);
      end
    end

    // Randomized traffic; inputs stay frozen while an access is outstanding.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!m_pending) begin
        valid_i    = ($urandom % 4) != 0;
        dREN_i     = $urandom % 2;
        dWEN_i     = $urandom % 2;
        halt_i     = ($urandom % 16) == 0;
        aluout_i   = $urandom;
        rdat2_i    = $urandom;
        pc4_i      = $urandom;
        lui_imm_i  = $urandom & 32'hFFFF_0000;
        MemToReg_i = 2'($urandom % 4);
        dhit       = ($urandom % 3) == 0;
      end else begin
        dhit = ($urandom % 5) == 0;
      end
      dmemload = $urandom;
      RST = (($urandom % 40) == 0) || (m_halted && ($urandom % 6) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
